// File: rtl/cmd_cfg_ext.sv
// rtl/cmd_cfg_ext.sv - Host command decoder with saturated setpoints, calibration sequencing, link watchdog and soft land
module cmd_cfg_ext #(
    parameter int CAL_W    = 9,
    parameter int THR_W    = 9,
    parameter int THR_MAX  = 400,
    parameter int ANG_LIM  = 5000,
    parameter int WD_W     = 16,
    parameter int RAMP_W   = 4,
    parameter int THR_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_rdy,
    input  logic [7:0]              cmd,
    input  logic [15:0]             data,
    input  logic                    cal_done,
    output logic                    clr_cmd_rdy,
    output logic                    send_resp,
    output logic [7:0]              resp,
    output logic signed [15:0]      d_ptch,
    output logic signed [15:0]      d_roll,
    output logic signed [15:0]      d_yaw,
    output logic [THR_W-1:0]        thrst,
    output logic                    strt_cal,
    output logic                    inertial_cal,
    output logic                    motors_off,
    output logic                    link_lost
);
    localparam logic [7:0] OP_PTCH = 8'h02;
    localparam logic [7:0] OP_ROLL = 8'h03;
    localparam logic [7:0] OP_YAW  = 8'h04;
    localparam logic [7:0] OP_THR  = 8'h05;
    localparam logic [7:0] OP_CAL  = 8'h06;
    localparam logic [7:0] OP_EMER = 8'h07;
    localparam logic [7:0] OP_MOFF = 8'h08;
    localparam logic [7:0] OP_SOFT = 8'h09;
    localparam logic [7:0] ACK     = 8'hA5;
    localparam logic [7:0] NACK    = 8'hEE;

    localparam logic signed [15:0] ANG_HI    = 16'(ANG_LIM);
    localparam logic signed [15:0] ANG_LO    = -ANG_HI;
    localparam logic [15:0]        THR_MAX16 = 16'(THR_MAX);
    localparam logic [THR_W-1:0]   THR_CAP   = THR_W'(THR_MAX);
    localparam logic [THR_W-1:0]   THR_DEC   = THR_W'(THR_STEP);
    // Counters fire on the edge that takes them to all-ones, giving 2^W-1 cycle waits.
    localparam logic [CAL_W-1:0]   CAL_LAST  = CAL_W'((1 << CAL_W) - 2);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'((1 << WD_W) - 2);

    typedef enum logic [2:0] {IDLE, DISPATCH, CAL_WAIT, CAL_RUN, LAND_RAMP} state_t;

    state_t              state;
    logic [CAL_W-1:0]    cal_cnt;
    logic [WD_W-1:0]     wd_cnt;
    logic [RAMP_W-1:0]   ramp_cnt;

    logic signed [15:0]  ang_sat;
    logic [THR_W-1:0]    thr_sat;
    logic [THR_W-1:0]    thr_next;
    logic                op_valid;
    logic                abort_op;

    always_comb begin
        ang_sat = $signed(data);
        if ($signed(data) > ANG_HI)
            ang_sat = ANG_HI;
        else if ($signed(data) < ANG_LO)
            ang_sat = ANG_LO;
    end

    assign thr_sat  = (data > THR_MAX16) ? THR_CAP : data[THR_W-1:0];
    assign thr_next = (thrst > THR_DEC) ? thrst - THR_DEC : '0;
    assign op_valid = (cmd >= OP_PTCH) && (cmd <= OP_SOFT);
    assign abort_op = cmd_rdy && ((cmd == OP_EMER) || (cmd == OP_MOFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cal_cnt      <= '0;
            wd_cnt       <= '0;
            ramp_cnt     <= '0;
            clr_cmd_rdy  <= 1'b0;
            send_resp    <= 1'b0;
            resp         <= 8'h00;
            d_ptch       <= '0;
            d_roll       <= '0;
            d_yaw        <= '0;
            thrst        <= '0;
            strt_cal     <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            link_lost    <= 1'b0;
        end else begin
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        wd_cnt      <= '0;
                        clr_cmd_rdy <= 1'b1;
                        state       <= DISPATCH;
                    end else if (motors_off) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        wd_cnt    <= '0;
                        link_lost <= 1'b1;
                        d_ptch    <= '0;
                        d_roll    <= '0;
                        d_yaw     <= '0;
                        ramp_cnt  <= '0;
                        state     <= LAND_RAMP;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                DISPATCH: begin
                    state <= IDLE;
                    if (op_valid)
                        link_lost <= 1'b0;
                    // Calibration acknowledges only once cal_done arrives.
                    if (cmd != OP_CAL) begin
                        send_resp <= 1'b1;
                        resp      <= op_valid ? ACK : NACK;
                    end
                    case (cmd)
                        OP_PTCH: d_ptch <= ang_sat;
                        OP_ROLL: d_roll <= ang_sat;
                        OP_YAW:  d_yaw  <= ang_sat;
                        OP_THR:  thrst  <= thr_sat;
                        OP_CAL: begin
                            motors_off   <= 1'b0;
                            cal_cnt      <= '0;
                            inertial_cal <= 1'b1;
                            state        <= CAL_WAIT;
                        end
                        OP_EMER: begin
                            d_ptch <= '0;
                            d_roll <= '0;
                            d_yaw  <= '0;
                            thrst  <= '0;
                        end
                        OP_MOFF: motors_off <= 1'b1;
                        OP_SOFT: begin
                            d_ptch   <= '0;
                            d_roll   <= '0;
                            d_yaw    <= '0;
                            ramp_cnt <= '0;
                            state    <= LAND_RAMP;
                        end
                        default: ;
                    endcase
                end
                CAL_WAIT: begin
                    cal_cnt <= cal_cnt + CAL_W'(1);
                    if (cal_cnt == CAL_LAST) begin
                        strt_cal <= 1'b1;
                        state    <= CAL_RUN;
                    end
                end
                CAL_RUN: begin
                    if (cal_done) begin
                        send_resp    <= 1'b1;
                        resp         <= ACK;
                        inertial_cal <= 1'b0;
                        state        <= IDLE;
                    end
                end
                LAND_RAMP: begin
                    // Only emergency land and motors-off may pre-empt the ramp.
                    if (abort_op) begin
                        clr_cmd_rdy <= 1'b1;
                        state       <= DISPATCH;
                    end else begin
                        ramp_cnt <= ramp_cnt + RAMP_W'(1);
                        if (&ramp_cnt) begin
                            thrst <= thr_next;
                            if (thr_next == '0) begin
                                motors_off <= 1'b1;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_cfg_ext.sv
// tb/tb_cmd_cfg_ext.sv - Scoreboard bench for cmd_cfg_ext with directed command vectors
module tb_cmd_cfg_ext;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_rdy = 1'b0;
    logic [7:0]         cmd = 8'h00;
    logic [15:0]        data = 16'h0000;
    logic               cal_done = 1'b0;
    logic               clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, link_lost;
    logic [7:0]         resp;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]         thrst;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    cmd_cfg_ext #(.WD_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .thrst(thrst), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
        .motors_off(motors_off), .link_lost(link_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && send_resp) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got %02h, none expected", resp);
            end else begin
                mon_exp = exp_q.pop_front();
                if (resp !== mon_exp) begin
                    n_fail++;
                    $display("FAIL resp_value: got %02h expected %02h", resp, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, input int max_wait, output int lat);
        cmd = c;
        data = d;
        cmd_rdy = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!clr_cmd_rdy && lat < max_wait);
        check("clr_seen", clr_cmd_rdy, 1);
        cmd_rdy = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [15:0] d, input logic [7:0] r, input bit has_resp);
        int lat;
        if (has_resp)
            exp_q.push_back(r);
        send_cmd(c, d, 8, lat);
        check("clr_latency", lat, 1);
        @(negedge clk);
        check("resp_timing", send_resp, has_resp);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ang"}, {d_ptch, d_roll, d_yaw}, 48'h0);
        check({name, "_ctl"}, {clr_cmd_rdy, send_resp, resp, thrst, strt_cal, inertial_cal, motors_off, link_lost},
              {1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0});
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t ang_v[7] = '{
        '{8'h02, 16'h0100, 16'h0100},
        '{8'h02, 16'h7FFF, 16'h1388},
        '{8'h02, 16'h8000, 16'hEC78},
        '{8'h03, 16'hEC78, 16'hEC78},
        '{8'h03, 16'hFFFF, 16'hFFFF},
        '{8'h04, 16'h1388, 16'h1388},
        '{8'h04, 16'hEC77, 16'hEC78}
    };

    vec_t thr_v[5] = '{
        '{8'h05, 16'h01F4, 16'h0190},
        '{8'h05, 16'h0191, 16'h0190},
        '{8'h05, 16'h0190, 16'h0190},
        '{8'h05, 16'h8000, 16'h0190},
        '{8'h05, 16'h0064, 16'h0064}
    };

    initial begin
        int lat;
        int k;
        logic [15:0] act;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (ang_v[i]) begin
            do_cmd(ang_v[i].op, ang_v[i].d, 8'hA5, 1'b1);
            case (ang_v[i].op)
                8'h02:   act = $unsigned(d_ptch);
                8'h03:   act = $unsigned(d_roll);
                default: act = $unsigned(d_yaw);
            endcase
            check("angle_sat", act, ang_v[i].exp);
        end

        foreach (thr_v[i]) begin
            do_cmd(thr_v[i].op, thr_v[i].d, 8'hA5, 1'b1);
            check("thrust_sat", thrst, thr_v[i].exp);
        end

        do_cmd(8'h3C, 16'h0020, 8'hEE, 1'b1);
        check("nack_thrst", thrst, 100);
        do_cmd(8'h00, 16'h0000, 8'hEE, 1'b1);
        check("nack_yaw", $unsigned(d_yaw), 16'hEC78);

        do_cmd(8'h07, 16'h0000, 8'hA5, 1'b1);
        check("emer_zero", {d_ptch, d_roll, d_yaw, 7'h0, thrst}, 64'h0);
        check("emer_motors", motors_off, 1);

        // Soft land from 10, aborted by motors-off after two steps.
        do_cmd(8'h05, 16'h000A, 8'hA5, 1'b1);
        do_cmd(8'h09, 16'h0000, 8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        exp_q.push_back(8'hA5);
        send_cmd(8'h08, 16'h0000, 8, lat);
        check("abort_latency", lat, 1);
        @(negedge clk);
        check("abort_resp", send_resp, 1);
        check("abort_thrst", thrst, 8);
        check("abort_motors", motors_off, 1);
        repeat (40) @(negedge clk);
        check("abort_hold", thrst, 8);

        // Non-abort opcode mid-ramp waits for the ramp to finish.
        do_cmd(8'h05, 16'h000A, 8'hA5, 1'b1);
        do_cmd(8'h09, 16'h0000, 8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        exp_q.push_back(8'hA5);
        send_cmd(8'h02, 16'h0200, 200, lat);
        check("pending_latency", lat, 121);
        @(negedge clk);
        check("pending_ptch", $unsigned(d_ptch), 16'h0200);
        check("pending_thrst", thrst, 0);
        check("pending_motors", motors_off, 1);

        // First calibration.
        do_cmd(8'h06, 16'h0000, 8'h00, 1'b0);
        check("cal_flags", {inertial_cal, motors_off}, 2'b10);
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("cal_wait", k, 511);
        @(negedge clk);
        check("strt_pulse", {strt_cal, inertial_cal}, 2'b01);
        repeat (5) @(negedge clk);
        exp_q.push_back(8'hA5);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("cal_ack", {send_resp, inertial_cal}, 2'b10);

        // Second calibration with cal_done and a command arriving together.
        do_cmd(8'h06, 16'h0000, 8'h00, 1'b0);
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("cal2_wait", k, 511);
        @(negedge clk);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        cal_done = 1'b1;
        cmd = 8'h05;
        data = 16'h0014;
        cmd_rdy = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("coinc_ack_first", {send_resp, clr_cmd_rdy}, 2'b10);
        @(negedge clk);
        check("coinc_cmd_next", clr_cmd_rdy, 1);
        cmd_rdy = 1'b0;
        @(negedge clk);
        check("coinc_thrst", thrst, 20);

        // Watchdog with motors on and no traffic.
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!link_lost && k < 100);
        check("wd_timeout", k, 63);
        check("wd_state", {d_ptch, 7'h0, thrst, 7'h0, motors_off}, {16'h0000, 7'h0, 9'd20, 7'h0, 1'b0});
        repeat (16) @(negedge clk);
        check("wd_step1", thrst, 19);
        k = 0;
        while (!motors_off && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("wd_land_time", k, 304);
        check("wd_land_end", {thrst, link_lost}, {9'd0, 1'b1});
        do_cmd(8'h08, 16'h0000, 8'hA5, 1'b1);
        check("link_clear", link_lost, 0);

        // Reset during CAL_RUN.
        do_cmd(8'h06, 16'h0000, 8'h00, 1'b0);
        k = 0;
        while (!strt_cal && k < 600) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_cal");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during LAND_RAMP.
        do_cmd(8'h05, 16'h000A, 8'hA5, 1'b1);
        do_cmd(8'h09, 16'h0000, 8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        check("ramp_before_rst", thrst, 9);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_ramp");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_idle", {thrst, motors_off}, {9'd0, 1'b1});
        do_cmd(8'h05, 16'h0005, 8'hA5, 1'b1);
        check("post_rst_cmd", thrst, 5);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cmd_cfg_ext.md
Name: cmd_cfg_ext

Overview:
Parametrised second-generation command decoder/configuration block. It sits between the BLE UART command receiver and the flight controller. It decodes 24-bit host commands into saturated attitude/thrust setpoints and sequences inertial calibration. New over the first generation: NACK for unknown opcodes, setpoint saturation, a link-loss watchdog, and a ramped soft-land mode.

Parameters:
CAL_W, 9, width of calibration spin-up timer; wait is 2^CAL_W-1 cycles (26 for silicon).
THR_W, 9, thrst width.
THR_MAX, 400, unsigned thrust ceiling.
ANG_LIM, 5000, symmetric saturation limit for d_ptch/d_roll/d_yaw (signed 16-bit).
WD_W, 16, link watchdog width; timeout is 2^WD_W-1 cycles without cmd_rdy.
RAMP_W, 4, soft-land step interval; one step per 2^RAMP_W cycles.
THR_STEP, 1, thrust decrement per ramp step.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_rdy  in  1  24-bit command available
cmd  in  8  opcode
data  in  16  parameter
cal_done  in  1  inertial calibration complete
clr_cmd_rdy  out  1  command consumed
send_resp  out  1  one-cycle pulse, transmit resp
resp  out  8  response byte
d_ptch, d_roll, d_yaw  out  16 signed  desired angles
thrst  out  THR_W  desired thrust
strt_cal  out  1  one-cycle calibration start
inertial_cal  out  1  high through calibration
motors_off  out  1  motors disabled
link_lost  out  1  watchdog fired (sticky)

Behaviour:
- Reset values: d_*=0, thrst=0, motors_off=1, link_lost=0, resp=0, send_resp=0, strt_cal=0, inertial_cal=0, clr_cmd_rdy=0, state IDLE, all timers 0.
- Opcodes: 02 ptch, 03 roll, 04 yaw, 05 thrst, 06 calibrate, 07 emer land, 08 motors off, 09 soft land. ACK=A5, NACK=EE.
- States: IDLE, DISPATCH, CAL_WAIT, CAL_RUN, LAND_RAMP.
- IDLE: cmd_rdy sampled high -> DISPATCH next cycle.
- DISPATCH (exactly 1 cycle):
  - clr_cmd_rdy=1 (Moore output).
  - Register update takes effect at the end of the cycle.
  - send_resp pulses in the following cycle, with resp valid then; resp holds until the next response.
  - Any valid opcode clears link_lost.
- 02/03/04: target = clamp($signed(data), -ANG_LIM, +ANG_LIM); ACK; -> IDLE.
- 05: thrst = (data > THR_MAX) ? THR_MAX : data[THR_W-1:0], using a 16-bit unsigned compare; ACK; -> IDLE. The write is accepted even when motors_off=1.
- 07: d_*=0 and thrst=0 immediately; motors_off unchanged; ACK; -> IDLE.
- 08: motors_off=1; ACK; -> IDLE.
- 09: d_*=0; ACK; -> LAND_RAMP.
- Unknown opcode: NACK, no register change, -> IDLE. It must never hang.
- 06 -> CAL_WAIT:
  - clr_cmd_rdy in DISPATCH; motors_off=0 on entry; cal timer cleared on entry.
  - inertial_cal=1 throughout CAL_WAIT and CAL_RUN.
- CAL_WAIT: when the timer reaches all-ones, pulse strt_cal for 1 cycle -> CAL_RUN.
- CAL_RUN: on cal_done, ACK -> IDLE. No ACK is sent before cal_done.
- Watchdog:
  - Counts every cycle while motors_off=0 and state is IDLE.
  - Clears on cmd_rdy, and holds at 0 while motors_off=1.
  - At all-ones: link_lost=1, d_*=0, -> LAND_RAMP. No response is sent.
- LAND_RAMP:
  - Every 2^RAMP_W cycles, thrst -= THR_STEP, saturating at 0 (no wrap).
  - When thrst==0: motors_off=1 -> IDLE. Entering with thrst=0 completes on the first step.
- cmd_rdy during LAND_RAMP: opcode 07 or 08 -> DISPATCH next cycle (ramp aborted). Other opcodes stay pending; clr_cmd_rdy is not asserted until the ramp completes.
- cmd_rdy during CAL_WAIT/CAL_RUN: held pending. If cal_done and cmd_rdy are both high in CAL_RUN, cal_done wins and the command is taken from IDLE.
- Reset mid-operation: immediate return to reset values, with the calibration or ramp abandoned.

Test Plan:
- cmd=02 data=0x0100 -> clr_cmd_rdy 1 cycle after cmd_rdy; d_ptch=0x0100; send_resp pulse with resp=A5 one cycle later. Then data=0x7FFF -> d_ptch=5000; data=0x8000 -> d_ptch=-5000.
- cmd=05 data=0x01F4 -> thrst=400 (clamped); data=0x0064 -> thrst=100; cmd=0x3C -> resp=EE, thrst still 100, FSM back in IDLE.
- cmd=06 -> motors_off falls; inertial_cal high; strt_cal pulses exactly 511 cycles later (CAL_W=9); no send_resp until cal_done, then resp=A5. cal_done coincident with cmd_rdy -> ACK first, command serviced next.
- WD_W=6, motors on, thrst=20, no commands -> link_lost=1 after 63 idle cycles; thrst decrements by 1 every 16 cycles; motors_off=1 when thrst hits 0; no send_resp during the sequence.
- cmd=09 with thrst=10, then cmd=08 mid-ramp -> ramp aborts, motors_off=1, ACK. Repeat with cmd=02 mid-ramp -> clr_cmd_rdy withheld until ramp completes.
- Assert rst_n low during CAL_RUN and during LAND_RAMP -> all outputs at reset values; motors_off=1.
